// File: rtl/boreal_spectral_pkg.sv
// rtl/boreal_spectral_pkg.sv - shared constants, FSM state type and band slice helper for the spectral framer
package boreal_spectral_pkg;

    localparam int NUM_BANDS  = 16;
    localparam int BAND_W     = 24;
    localparam int VEC_W      = NUM_BANDS * BAND_W;
    localparam int BAND_IDX_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Band b of a packed spectral vector lives at bits [b*BAND_W +: BAND_W].
    function automatic logic [BAND_W-1:0] band_slice(
        input logic [VEC_W-1:0]      vec,
        input logic [BAND_IDX_W-1:0] band
    );
        return vec[band*BAND_W +: BAND_W];
    endfunction

endpackage

// File: rtl/boreal_log2_compress.sv
// rtl/boreal_log2_compress.sv - combinational 24-bit envelope to 8-bit {exponent, 3-bit mantissa} compressor
//
// Ports:
//   in_word   in  24  unsigned envelope
//   out_code  out 8   {e[4:0], f[2:0]}: e = msb index + 1 (0 for zero input),
//                     f = the three bits directly below the msb, zero padded
module boreal_log2_compress (
    input  logic [23:0] in_word,
    output logic [7:0]  out_code
);

    logic [4:0] msb;
    logic [2:0] frac;
    int         pos;

    always_comb begin
        msb  = 5'd0;
        frac = 3'd0;
        pos  = 0;
        for (int i = 0; i < 24; i++) begin
            if (in_word[i]) msb = 5'(i);
        end
        // Bits below bit 0 do not exist; those mantissa positions stay zero.
        for (int k = 0; k < 3; k++) begin
            pos = int'(msb) - 1 - k;
            if (pos >= 0) frac[2-k] = in_word[pos];
        end
    end

    assign out_code = (in_word == 24'd0) ? 8'd0 : {msb + 5'd1, frac};

endmodule

// File: rtl/boreal_spectral_framer.sv
// rtl/boreal_spectral_framer.sv - decimating 2-slot ping-pong frame buffer serializing 16 band words on a valid/ready stream
//
// Parameters: DECIM (1..256) samples per captured frame, NUM_BANDS (16), BAND_W (24).
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   in_valid           spectral vector strobe
//   spectral_vector    NUM_BANDS*BAND_W packed envelopes, band b at [b*BAND_W +: BAND_W]
//   m_valid/m_ready    output word handshake
//   m_data/m_band      band word and its index
//   m_first/m_last     band 0 / band 15 markers
//   frame_cnt          frames fully sent (wrapping)
//   drop_cnt           frames dropped for lack of a slot (saturating)
//   busy               any slot full or a frame in flight
// Build option: BOREAL_FRAMER_LOG2_EN selects log2-compressed m_data instead of raw envelopes.
module boreal_spectral_framer #(
    parameter int DECIM     = 8,
    parameter int NUM_BANDS = 16,
    parameter int BAND_W    = 24
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    input  logic [NUM_BANDS*BAND_W-1:0] spectral_vector,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [BAND_W-1:0]           m_data,
    output logic [3:0]                  m_band,
    output logic                        m_first,
    output logic                        m_last,
    output logic [15:0]                 frame_cnt,
    output logic [15:0]                 drop_cnt,
    output logic                        busy
);

    import boreal_spectral_pkg::*;

    localparam logic [7:0] DEC_LAST = 8'(DECIM - 1);

    logic [VEC_W-1:0]      slot [2];
    logic [1:0]            full;
    logic [1:0]            full_nxt;
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [7:0]            dec_cnt;
    logic [BAND_IDX_W-1:0] band_idx;
    state_t                state;
    logic                  valid_q;

    logic                  cap_evt;
    logic                  cap_ok;
    logic                  hs;
    logic                  rel;
    logic [BAND_W-1:0]     word_raw;
    logic [BAND_W-1:0]     word_out;

    assign cap_evt = in_valid && (dec_cnt == DEC_LAST);
    assign hs      = valid_q && m_ready;
    assign rel     = hs && (band_idx == 4'd15);
    // A full slot still accepts a capture when its last word leaves on this edge.
    assign cap_ok  = cap_evt && (!full[wr_ptr] || (rel && (rd_ptr == wr_ptr)));

    always_comb begin
        full_nxt = full;
        if (rel)    full_nxt[rd_ptr] = 1'b0;
        if (cap_ok) full_nxt[wr_ptr] = 1'b1;
    end

    // Payload storage carries no reset; full flags alone decide validity.
    always_ff @(posedge clk) begin
        if (cap_ok) slot[wr_ptr] <= spectral_vector;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_cnt   <= 8'd0;
            full      <= 2'b00;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            band_idx  <= '0;
            state     <= IDLE;
            valid_q   <= 1'b0;
            frame_cnt <= 16'd0;
            drop_cnt  <= 16'd0;
        end else begin
            if (in_valid) dec_cnt <= (dec_cnt == DEC_LAST) ? 8'd0 : dec_cnt + 8'd1;
            full <= full_nxt;
            if (cap_ok) wr_ptr <= ~wr_ptr;
            if (cap_evt && !cap_ok && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;

            case (state)
                IDLE: begin
                    if (full[rd_ptr]) begin
                        state    <= SEND;
                        valid_q  <= 1'b1;
                        band_idx <= '0;
                    end
                end
                SEND: begin
                    if (hs) begin
                        band_idx <= band_idx + 4'd1;
                        if (rel) begin
                            rd_ptr    <= ~rd_ptr;
                            frame_cnt <= frame_cnt + 16'd1;
                            if (!full[~rd_ptr]) begin
                                state   <= IDLE;
                                valid_q <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign word_raw = band_slice(slot[rd_ptr], band_idx);

`ifdef BOREAL_FRAMER_LOG2_EN
    logic [7:0] word_log;

    boreal_log2_compress u_log2 (
        .in_word  (word_raw),
        .out_code (word_log)
    );

    assign word_out = {16'd0, word_log};
`else
    assign word_out = word_raw;
`endif

    // Outputs derive only from registered state, never from in_valid or m_ready.
    assign m_valid = valid_q;
    assign m_data  = valid_q ? word_out : '0;
    assign m_band  = band_idx;
    assign m_first = valid_q && (band_idx == 4'd0);
    assign m_last  = valid_q && (band_idx == 4'd15);
    assign busy    = (|full) || (state == SEND);

endmodule

// File: tb/tb_boreal_spectral_framer.sv
// tb/tb_boreal_spectral_framer.sv - self-checking bench for boreal_spectral_framer with a frame-queue reference model
module tb_boreal_spectral_framer;

    localparam int DECIM = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [383:0] spectral_vector = '0;
    logic         m_ready = 1'b0;
    logic         m_valid;
    logic [23:0]  m_data;
    logic [3:0]   m_band;
    logic         m_first;
    logic         m_last;
    logic [15:0]  frame_cnt;
    logic [15:0]  drop_cnt;
    logic         busy;

    int checks = 0;
    int errors = 0;

    // Reference model: frames held in the buffer, expressed as a word queue plus counts.
    logic [23:0] exp_q[$];
    int          pending;
    bit          sending;
    int          mband;
    int          samples;
    int          m_frames;
    int          m_drops;

    boreal_spectral_framer #(.DECIM(DECIM)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .spectral_vector (spectral_vector),
        .m_valid         (m_valid),
        .m_ready         (m_ready),
        .m_data          (m_data),
        .m_band          (m_band),
        .m_first         (m_first),
        .m_last          (m_last),
        .frame_cnt       (frame_cnt),
        .drop_cnt        (drop_cnt),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] xform(input logic [23:0] v);
`ifdef BOREAL_FRAMER_LOG2_EN
        int e;
        int f;
        e = 0;
        for (int i = 0; i < 24; i++) if ((v >> i) & 24'd1) e = i + 1;
        if (e == 0) return 24'd0;
        if (e >= 4) f = int'((v >> (e - 4)) & 24'd7);
        else        f = int'((v << (4 - e)) & 24'd7);
        return 24'(e * 8 + f);
`else
        return v;
`endif
    endfunction

    function automatic logic [383:0] rand_vec();
        logic [383:0] v;
        for (int b = 0; b < 16; b++) v[b*24 +: 24] = 24'($urandom);
        return v;
    endfunction

    function automatic logic [383:0] ramp_vec();
        logic [383:0] v;
        for (int b = 0; b < 16; b++) v[b*24 +: 24] = 24'(32'h100 + b);
        return v;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        pending  = 0;
        sending  = 0;
        mband    = 0;
        samples  = 0;
        m_frames = 0;
        m_drops  = 0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, m_valid, 0);
        chk({tag, "_data"},  m_data, 0);
        chk({tag, "_band"},  m_band, 0);
        chk({tag, "_first"}, m_first, 0);
        chk({tag, "_last"},  m_last, 0);
        chk({tag, "_frames"}, frame_cnt, 0);
        chk({tag, "_drops"}, drop_cnt, 0);
        chk({tag, "_busy"},  busy, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        m_ready  = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
    endtask

    // One clock: check outputs against the model, drive inputs, advance the model across the edge.
    task automatic cycle(input logic iv, input logic [383:0] vec, input logic rdy);
        bit rel;
        bit nxt_send;
        @(negedge clk);
        chk("m_valid", m_valid, sending);
        chk("frame_cnt", frame_cnt, m_frames);
        chk("drop_cnt", drop_cnt, m_drops);
        chk("busy", busy, pending > 0);
        if (sending && exp_q.size() > 0) begin
            chk("m_data", m_data, xform(exp_q[0]));
            chk("m_band", m_band, mband);
            chk("m_first", m_first, mband == 0);
            chk("m_last", m_last, mband == 15);
        end
        in_valid        = iv;
        spectral_vector = vec;
        m_ready         = rdy;

        rel = 0;
        if (sending && rdy) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            if (mband == 15) begin
                rel = 1;
                pending--;
                m_frames = (m_frames + 1) % 65536;
            end
            mband = (mband + 1) % 16;
        end
        if (sending) nxt_send = rel ? (pending > 0) : 1'b1;
        else         nxt_send = (pending > 0);
        if (iv) begin
            if (samples % DECIM == DECIM - 1) begin
                if (pending < 2) begin
                    for (int b = 0; b < 16; b++) exp_q.push_back(vec[b*24 +: 24]);
                    pending++;
                end else if (m_drops < 65535) begin
                    m_drops++;
                end
            end
            samples++;
        end
        sending = nxt_send;
    endtask

    initial begin
        logic [15:0] drops_before;
        model_reset();

        // Decimation and ordering: 8 pulses of a ramp vector give two frames.
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'b1, ramp_vec(), 1'b1);
        for (int i = 0; i < 40; i++) cycle(1'b0, '0, 1'b1);
        chk("ramp_frames", frame_cnt, 2);
        chk("ramp_idle", m_valid, 0);

        // Backpressure: alternating ready must hold each word until accepted.
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, rand_vec(), 1'b1);
        for (int i = 0; i < 40; i++) cycle(1'b0, '0, logic'(i % 2 == 0));
        chk("bp_frames", frame_cnt, 1);

        // Drop: three captures with no downstream accept, then drain.
        do_reset();
        for (int i = 0; i < 12; i++) cycle(1'b1, rand_vec(), 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b0);
        chk("drop_count", drop_cnt, 1);
        for (int i = 0; i < 40; i++) cycle(1'b0, '0, 1'b1);
        chk("drop_frames", frame_cnt, 2);
        chk("drop_count_after", drop_cnt, 1);

        // Release and capture on the same edge with both slots full.
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'b1, rand_vec(), 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, rand_vec(), 1'b0);
        drops_before = drop_cnt;
        for (int i = 0; i < 16; i++) cycle(logic'(i == 15), rand_vec(), 1'b1);
        for (int i = 0; i < 40; i++) cycle(1'b0, '0, 1'b1);
        chk("same_edge_drops", drop_cnt, 32'(drops_before));
        chk("same_edge_frames", frame_cnt, 3);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 600; i++)
            cycle(logic'($urandom_range(0, 2) == 0), rand_vec(), logic'($urandom_range(0, 3) != 0));
        for (int i = 0; i < 60; i++) cycle(1'b0, '0, 1'b1);

        // Reset mid-frame after band 5 is accepted.
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, rand_vec(), 1'b0);
        cycle(1'b0, '0, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1);
        @(negedge clk);
        chk("mid_band", m_band, 6);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("mid_reset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) cycle(1'b0, '0, 1'b1);
        chk("post_reset_idle", m_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
